// File: rtl/button_conditioner.sv
// button_conditioner: synchronise, debounce and classify a raw push-button into level, press/release/long strobes.
// Optional auto-repeat strobes on o_repeat when BTN_AUTO_REPEAT_EN is defined.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES   = 2000000,
   parameter int LONG_PRESS_CYCLES = 400000000,
   parameter int REPEAT_CYCLES     = 40000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long,
   output logic o_repeat
);
   localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HMAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
   localparam int HW   = $clog2(HMAX + 1);
   localparam logic [DW-1:0] DB_C   = DW'(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DB_ONE = DW'(1);
   localparam logic [HW-1:0] LP_M1  = HW'(LONG_PRESS_CYCLES - 1);
   localparam logic [HW-1:0] HMAX_C = HW'(HMAX);
`ifdef BTN_AUTO_REPEAT_EN
   localparam logic [HW-1:0] RP_M1  = HW'(REPEAT_CYCLES - 1);
`endif

   typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;

   state_t          state_q;
   logic [1:0]      sync_q;
   logic [DW-1:0]   db_q;
   logic [HW-1:0]   hold_q;
   logic            long_q;
   logic            s;

   assign s = sync_q[1];

`ifndef BTN_AUTO_REPEAT_EN
   assign o_repeat = 1'b0;
`endif

   // Hold counter compares against value-minus-one so a strobe lands exactly N cycles after its reference strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sync_q    <= '0;
         db_q      <= '0;
         hold_q    <= '0;
         long_q    <= 1'b0;
         o_level   <= 1'b0;
         o_press   <= 1'b0;
         o_release <= 1'b0;
         o_long    <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
         o_repeat  <= 1'b0;
`endif
      end else begin
         sync_q    <= {sync_q[0], i_btn};
         o_press   <= 1'b0;
         o_release <= 1'b0;
         o_long    <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
         o_repeat  <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (s) begin
                  state_q <= DB_PRESS;
                  db_q    <= DB_ONE;
               end
            end
            DB_PRESS: begin
               if (!s) begin
                  state_q <= IDLE;
                  db_q    <= '0;
               end else if (db_q == DB_C) begin
                  state_q <= HELD;
                  o_level <= 1'b1;
                  o_press <= 1'b1;
                  hold_q  <= '0;
                  long_q  <= 1'b0;
               end else begin
                  db_q <= db_q + DB_ONE;
               end
            end
            HELD: begin
               if (!s) begin
                  state_q <= DB_RELEASE;
                  db_q    <= DB_ONE;
               end else if (!long_q && hold_q == LP_M1) begin
                  o_long <= 1'b1;
                  long_q <= 1'b1;
                  hold_q <= '0;
`ifdef BTN_AUTO_REPEAT_EN
               end else if (long_q && hold_q == RP_M1) begin
                  o_repeat <= 1'b1;
                  hold_q   <= '0;
`endif
               end else if (hold_q != HMAX_C) begin
                  hold_q <= hold_q + 1'b1;
               end
            end
            DB_RELEASE: begin
               if (s) begin
                  state_q <= HELD;
               end else if (db_q == DB_C) begin
                  state_q   <= IDLE;
                  db_q      <= '0;
                  o_level   <= 1'b0;
                  o_release <= 1'b1;
               end else begin
                  db_q <= db_q + DB_ONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of press/release/long/repeat timing with DEBOUNCE=4, LONG=20, REPEAT=5.
module tb_button_conditioner;
   logic clk = 1'b0;
   logic rst_n;
   logic i_btn;
   logic o_level, o_press, o_release, o_long, o_repeat;
   int   compared = 0;
   int   mismatched = 0;
   logic [4:0] got, exp;

`ifdef BTN_AUTO_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   button_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .LONG_PRESS_CYCLES(20),
      .REPEAT_CYCLES(5)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .i_btn(i_btn),
      .o_level(o_level),
      .o_press(o_press),
      .o_release(o_release),
      .o_long(o_long),
      .o_repeat(o_repeat)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      i_btn = 1'b0;
      tick();
      tick();
      got = {o_level, o_press, o_release, o_long, o_repeat};
      compared++;
      if (got !== 5'b0) begin
         mismatched++;
         $display("FAIL reset_hold got=%b exp=00000", got);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         got = {o_level, o_press, o_release, o_long, o_repeat};
         compared++;
         if (got !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_idle c=%0d got=%b exp=00000", c, got);
         end
      end
   endtask

   task automatic test_clean_press;
      for (int c = 0; c < 12; c++) begin
         i_btn = 1'b1;
         tick();
         got = {o_level, o_press, o_release, o_long, o_repeat};
         exp = {c >= 6, c == 6, 1'b0, 1'b0, 1'b0};
         compared++;
         if (got !== exp) begin
            mismatched++;
            $display("FAIL clean_press c=%0d got=%b exp=%b", c, got, exp);
         end
      end
      for (int c = 0; c < 10; c++) begin
         i_btn = 1'b0;
         tick();
         got = {o_level, o_press, o_release, o_long, o_repeat};
         exp = {c < 6, 1'b0, c == 6, 1'b0, 1'b0};
         compared++;
         if (got !== exp) begin
            mismatched++;
            $display("FAIL clean_release c=%0d got=%b exp=%b", c, got, exp);
         end
      end
   endtask

   task automatic test_bounce;
      for (int c = 0; c < 16; c++) begin
         i_btn = (c < 4) ? ((c % 2) == 0) : 1'b0;
         tick();
         got = {o_level, o_press, o_release, o_long, o_repeat};
         compared++;
         if (got !== 5'b0) begin
            mismatched++;
            $display("FAIL bounce c=%0d got=%b exp=00000", c, got);
         end
      end
   endtask

   task automatic test_long_release;
      for (int c = 0; c < 56; c++) begin
         i_btn = (c < 40);
         tick();
         got = {o_level, o_press, o_release, o_long, o_repeat};
         exp = {c >= 6 && c < 46, c == 6, c == 46, c == 26,
                REP_EN && (c == 31 || c == 36 || c == 41)};
         compared++;
         if (got !== exp) begin
            mismatched++;
            $display("FAIL long_release c=%0d got=%b exp=%b", c, got, exp);
         end
      end
   endtask

   task automatic test_reset_mid_press;
      for (int c = 0; c < 10; c++) begin
         i_btn = 1'b1;
         tick();
      end
      compared++;
      if (o_level !== 1'b1) begin
         mismatched++;
         $display("FAIL mid_held_level got=%b exp=1", o_level);
      end
      rst_n = 1'b0;
      #1;
      got = {o_level, o_press, o_release, o_long, o_repeat};
      compared++;
      if (got !== 5'b0) begin
         mismatched++;
         $display("FAIL async_reset got=%b exp=00000", got);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         got = {o_level, o_press, o_release, o_long, o_repeat};
         compared++;
         if (got !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_low c=%0d got=%b exp=00000", c, got);
         end
      end
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         got = {o_level, o_press, o_release, o_long, o_repeat};
         exp = {c >= 6, c == 6, 1'b0, 1'b0, 1'b0};
         compared++;
         if (got !== exp) begin
            mismatched++;
            $display("FAIL repress c=%0d got=%b exp=%b", c, got, exp);
         end
      end
      i_btn = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      i_btn = 1'b0;
      @(negedge clk);
      test_reset();
      test_clean_press();
      test_bounce();
      test_long_release();
      test_reset_mid_press();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
